// File: rtl/booth_mac_unit.sv
// Signed radix-2 Booth multiply-accumulate unit: one WIDTH-iteration multiply per Run edge, optional accumulate.
// Optional feature: define ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module booth_mac_unit #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+8
) (
   input  logic                   Clk,
   input  logic                   Reset_Clear_N,
   input  logic                   Run,
   input  logic                   Accumulate,
   input  logic                   Clear_Acc,
   input  logic [WIDTH-1:0]       Multiplicand,
   input  logic [WIDTH-1:0]       Multiplier,
   output logic                   Busy,
   output logic                   Done,
   output logic [2*WIDTH-1:0]     Product,
   output logic [ACC_WIDTH-1:0]   Acc,
   output logic                   Acc_Ovf
);

   localparam int CNT_W = $clog2(WIDTH+1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH-1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                        state, state_nxt;
   logic                          run_q, start, mode, q_m1;
   logic signed [WIDTH:0]         s_reg, a_reg, a_sum;
   logic [WIDTH-1:0]              b_reg;
   logic [CNT_W-1:0]              count;
   logic signed [2*WIDTH-1:0]     prod_nxt;
   logic signed [ACC_WIDTH-1:0]   acc_reg, acc_base, addend, acc_sum, acc_nxt;
   logic                          ovf_hit;

   function automatic logic signed [WIDTH:0] booth_step(
      input logic signed [WIDTH:0] a,
      input logic signed [WIDTH:0] s,
      input logic [1:0]            sel
   );
      case (sel)
         2'b10:   return a - s;
         2'b01:   return a + s;
         default: return a;
      endcase
   endfunction

`ifdef ACC_SATURATE_EN
   function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
      input logic signed [ACC_WIDTH-1:0] sum,
      input logic                        neg,
      input logic                        ovf
   );
      if (!ovf) return sum;
      return neg ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
   endfunction
`endif

   assign start    = Run & ~run_q;
   assign a_sum    = booth_step(a_reg, s_reg, {b_reg[0], q_m1});
   assign prod_nxt = {a_reg[WIDTH-1:0], b_reg};

   // Clear is applied before the add so a coincident clear leaves just this product.
   assign acc_base = Clear_Acc ? '0 : acc_reg;
   assign addend   = ACC_WIDTH'(prod_nxt);
   assign acc_sum  = acc_base + addend;
   assign ovf_hit  = (acc_base[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                     (acc_sum[ACC_WIDTH-1]  != addend[ACC_WIDTH-1]);
`ifdef ACC_SATURATE_EN
   assign acc_nxt  = sat_acc(acc_sum, addend[ACC_WIDTH-1], ovf_hit);
`else
   assign acc_nxt  = acc_sum;
`endif

   assign Acc = acc_reg;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (count == LAST_ITER) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_Clear_N) begin
      if (!Reset_Clear_N) begin
         state   <= IDLE;
         run_q   <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         count   <= '0;
         Product <= '0;
         acc_reg <= '0;
         Acc_Ovf <= 1'b0;
      end else begin
         state <= state_nxt;
         run_q <= Run;
         Done  <= 1'b0;
         case (state)
            IDLE: if (start) begin
               Busy  <= 1'b1;
               count <= '0;
            end
            CALC: count <= count + 1'b1;
            DONE: begin
               Product <= prod_nxt;
               Done    <= 1'b1;
               Busy    <= 1'b0;
            end
            default: ;
         endcase
         if (state == DONE && mode) begin
            acc_reg <= acc_nxt;
            Acc_Ovf <= (Acc_Ovf & ~Clear_Acc) | ovf_hit;
         end else if (Clear_Acc) begin
            acc_reg <= '0;
            Acc_Ovf <= 1'b0;
         end
      end
   end

   // Datapath: operands latched on start, then add/sub and arithmetic shift of {A,B,q_-1} each CALC cycle.
   always_ff @(posedge Clk) begin
      case (state)
         IDLE: if (start) begin
            s_reg <= {Multiplicand[WIDTH-1], Multiplicand};
            b_reg <= Multiplier;
            mode  <= Accumulate;
            a_reg <= '0;
            q_m1  <= 1'b0;
         end
         CALC: begin
            a_reg <= {a_sum[WIDTH], a_sum[WIDTH:1]};
            b_reg <= {a_sum[0], b_reg[WIDTH-1:1]};
            q_m1  <= b_reg[0];
         end
         default: ;
      endcase
   end

endmodule
